aes_encrypt_core: RTL and testbench
===================================

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 (10 rounds, 11 round keys).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 roundkeys  input  1408  expanded key schedule from the key-expansion stage; round key r = roundkeys[1407-128*r -: 128], r = 0..10.
REQ-005 keys_valid  input  1  high when roundkeys is complete; driven by the key-expansion finish output.
REQ-006 start  input  1  request to encrypt plaintext.
REQ-007 plaintext  input  128  input block; sampled only on the accepting edge.
REQ-008 ciphertext  output  128  registered result; held stable until the next accepted start or reset.
REQ-009 busy  output  1  high while a block is in flight.
REQ-010 done  output  1  one-cycle pulse when ciphertext becomes valid.

Function
REQ-011 Byte order: state byte n = bits [127-8n -: 8]; column c = bytes 4c..4c+3 (FIPS-197 column-major). The same mapping applies to round keys and ciphertext.
REQ-012 FSM has two states, IDLE and RUN, plus a 4-bit round counter rnd.
REQ-013 IDLE -> RUN on an edge where start=1 and keys_valid=1. On that edge: state <= plaintext XOR rk0, rnd <= 1, busy <= 1.
REQ-014 In IDLE, start with keys_valid=0 is ignored; no state change.
REQ-015 In RUN with rnd in 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) XOR rk[rnd], and rnd <= rnd+1.
REQ-016 In RUN with rnd=10: final round without MixColumns. ciphertext <= result, done <= 1, busy <= 0, FSM -> IDLE.
REQ-017 Latency: start accepted on edge T; ciphertext valid and done=1 from edge T+10. done lasts exactly one cycle.
REQ-018 SubBytes uses 16 instances of the existing combinational sbox module (in[7:0] -> out[7:0]). No pipeline registers are allowed inside a round.
REQ-019 ShiftRows: row r of the state is rotated left by r columns.
REQ-020 MixColumns uses GF(2^8) xtime(b) = {b[6:0],0} XOR (b[7] ? 8'h1B : 8'h00). Each output column is [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] times the input column.
REQ-021 start while busy=1 is ignored; the block in flight is unaffected.
REQ-022 start in the same cycle that done=1 is accepted (FSM is already IDLE). This gives back-to-back blocks every 11 cycles.
REQ-023 roundkeys must remain stable while busy. A change of keys_valid while in RUN has no effect on the operation in progress.
REQ-024 ciphertext changes only on the edge that asserts done, or on reset.

Reset
REQ-025 On an edge with rst=1: FSM=IDLE, rnd=0, busy=0, done=0, ciphertext=0, internal state=0.
REQ-026 rst overrides start in the same cycle; the start is not accepted.
REQ-027 rst during RUN aborts the block with no done pulse. The next accepted start begins a fresh encryption.

Verification
REQ-028 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32, with done at T+10.
REQ-029 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 start pulsed with keys_valid=0 -> busy stays 0 and no done. Raising keys_valid and pulsing start -> normal result 10 cycles later.
REQ-031 start re-asserted at T+4 with a different plaintext -> ignored; result equals the first block only.
REQ-032 Back-to-back: second start in the done cycle with App. C.1 pt -> second done at T+21 with the correct ciphertext.
REQ-033 rst asserted at T+5 -> busy=0, done never pulses, ciphertext=0. A subsequent App. B run -> correct result.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128 encryption core, one round per clock

// Combinational AES S-box lookup
module sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table entry n sits at the top of the flat constant, byte 0 first
  always_comb begin
    out = SBOX_TABLE[2047 - 8*in -: 8];
  end

endmodule

// AES-128 round engine fed by an externally expanded key schedule
module aes_encrypt_core (
  input  logic          clk,
  input  logic          rst,
  input  logic [1407:0] roundkeys,
  input  logic          keys_valid,
  input  logic          start,
  input  logic [127:0]  plaintext,
  output logic [127:0]  ciphertext,
  output logic          busy,
  output logic          done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   fsm;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes: one S-box per state byte, purely combinational
  for (genvar n = 0; n < 16; n++) begin : g_sbox
    sbox u_sbox (
      .in  (st[127 - 8*n -: 8]),
      .out (sb[127 - 8*n -: 8])
    );
  end

  // ShiftRows: output (row r, column c) takes input (row r, column c+r)
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end

  // MixColumns applied column by column
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mixcol(sr[127 - 32*c -: 32]);
    end
  end

  // Round key for the current round; only rounds 1..10 are consumed here
  always_comb begin
    rk = '0;
    for (int r = 1; r <= 10; r++) begin
      if (rnd == r[3:0]) rk = roundkeys[1407 - 128*r -: 128];
    end
  end

  // Control FSM and state register: initial whitening, 9 full rounds, final round
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      rnd        <= 4'd0;
      st         <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start && keys_valid) begin
            st   <= plaintext ^ roundkeys[1407 -: 128];
            rnd  <= 4'd1;
            busy <= 1'b1;
            fsm  <= RUN;
          end
        end
        RUN: begin
          if (rnd == 4'd10) begin
            ciphertext <= sr ^ rk;
            done       <= 1'b1;
            busy       <= 1'b0;
            rnd        <= 4'd0;
            fsm        <= IDLE;
          end else begin
            st  <= mc ^ rk;
            rnd <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - directed FIPS-197 vector bench for aes_encrypt_core

module tb_aes_encrypt_core;

  logic          clk;
  logic          rst;
  logic [1407:0] roundkeys;
  logic          keys_valid;
  logic          start;
  logic [127:0]  plaintext;
  logic [127:0]  ciphertext;
  logic          busy;
  logic          done;

  int n_tests;
  int n_fail;
  int cyc;
  int t_acc;
  int t_first;
  int done_seen;
  logic [7:0] sbox_t [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_encrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .roundkeys  (roundkeys),
    .keys_valid (keys_valid),
    .start      (start),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[1407 - 32*i -: 32] = w[i];
    return res;
  endfunction

  // Pulse start for one edge; t_acc records the accepting edge
  task automatic launch(input logic [127:0] pt);
    plaintext = pt;
    start = 1'b1;
    tick();
    start = 1'b0;
    t_acc = cyc;
  endtask

  // Wait (bounded) for done; reports the timeout as a failed comparison
  task automatic wait_done(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      tick();
    end
    check({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  initial begin
    logic [2047:0] flat;
    flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_t[i] = flat[2047 - 8*i -: 8];

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst = 1'b1;
    start = 1'b0;
    keys_valid = 1'b1;
    plaintext = '0;
    roundkeys = expand(KEY_B);
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    check("keysched_rk10", roundkeys[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // App. B vector with exact latency and one-cycle done
    launch(PT_B);
    check("b_busy", {127'd0, busy}, 128'd1);
    wait_done("b");
    check("b_latency", 128'(cyc - t_acc), 128'd10);
    check("b_ct", ciphertext, CT_B);
    check("b_busy_done", {127'd0, busy}, 128'd0);
    tick();
    check("b_done_1cyc", {127'd0, done}, 128'd0);
    check("b_ct_hold", ciphertext, CT_B);

    // start without keys_valid is ignored, then a normal App. C.1 run
    roundkeys = expand(KEY_C);
    keys_valid = 1'b0;
    launch(PT_C);
    check("nokv_busy", {127'd0, busy}, 128'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("nokv_no_done", 128'(done_seen), 128'd0);
    check("nokv_ct_hold", ciphertext, CT_B);
    keys_valid = 1'b1;
    launch(PT_C);
    wait_done("c");
    check("c_latency", 128'(cyc - t_acc), 128'd10);
    check("c_ct", ciphertext, CT_C);

    // Restart at T+4 with different data and a keys_valid drop are ignored
    tick();
    roundkeys = expand(KEY_B);
    launch(PT_B);
    tick();
    tick();
    tick();
    plaintext = PT_C;
    start = 1'b1;
    keys_valid = 1'b0;
    tick();
    start = 1'b0;
    keys_valid = 1'b1;
    wait_done("restart");
    check("restart_latency", 128'(cyc - t_acc), 128'd10);
    check("restart_ct", ciphertext, CT_B);

    // Back-to-back: second start in the done cycle
    tick();
    launch(PT_B);
    t_first = t_acc;
    wait_done("bb1");
    check("bb1_ct", ciphertext, CT_B);
    roundkeys = expand(KEY_C);
    launch(PT_C);
    check("bb2_busy", {127'd0, busy}, 128'd1);
    wait_done("bb2");
    check("bb2_latency", 128'(cyc - t_first), 128'd21);
    check("bb2_ct", ciphertext, CT_C);

    // Reset at T+5 aborts the block, then a fresh App. B run
    tick();
    roundkeys = expand(KEY_B);
    launch(PT_B);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_ct", ciphertext, 128'd0);
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort_no_done", 128'(done_seen), 128'd0);
    check("abort_ct_hold", ciphertext, 128'd0);
    launch(PT_B);
    wait_done("after_abort");
    check("after_abort_latency", 128'(cyc - t_acc), 128'd10);
    check("after_abort_ct", ciphertext, CT_B);

    // Reset wins over a simultaneous start
    tick();
    rst = 1'b1;
    launch(PT_C);
    rst = 1'b0;
    check("rst_vs_start_busy", {127'd0, busy}, 128'd0);
    check("rst_vs_start_ct", ciphertext, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
